inst_loader: RTL and testbench



---
 rtl/inst_pkg.sv | 13 +
 rtl/loader_word_asm.sv | 34 +++
 rtl/inst_loader.sv | 125 ++++++++++++
 tb/tb_inst_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared constants for the instruction store and its byte-stream loader.
package inst_pkg;

  localparam int INST_ADDR_W  = 6;
  localparam int INST_DEPTH   = 2 ** INST_ADDR_W;
  localparam int LOAD_TIMEOUT = 100000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

endpackage

// File: rtl/loader_word_asm.sv
// Big-endian 4-byte word assembler: shifts accepted bytes in MSB first and
// flags the cycle in which the fourth byte completes a word.
module loader_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  idx;
  logic [23:0] shreg;

  // The completed word is formed combinationally so the writer can register
  // it on the same edge that takes in the fourth byte.
  assign word       = {shreg, byte_data};
  assign word_ready = accept && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= 2'd0;
      shreg <= 24'd0;
    end else if (clear) begin
      idx   <= 2'd0;
      shreg <= 24'd0;
    end else if (accept) begin
      idx   <= idx + 2'd1;
      shreg <= {shreg[15:0], byte_data};
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction RAM loader: header byte gives the word count, then 4 bytes per
// word are written out while the CPU is held; aborts on inter-byte timeout.
module inst_loader
  import inst_pkg::*;
#(
  parameter int ADDR_W  = INST_ADDR_W,
  parameter int TIMEOUT = LOAD_TIMEOUT,
  parameter int TO_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int N_W = ADDR_W + 1;
  localparam logic [N_W-1:0]  DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [N_W-1:0]  n_words;
  logic [N_W-1:0]  wcnt;
  logic            last_p;
  logic [TO_W-1:0] to_cnt;
  logic            accept;
  logic [31:0]     word;
  logic            word_ready;

  // Header count: 0 means a full store, anything beyond the store clamps.
  function automatic logic [N_W-1:0] sat_count(input logic [N_W-1:0] v);
    if (v == '0 || v > DEPTH) return DEPTH;
    return v;
  endfunction

  assign accept = (state == ST_DATA) && byte_valid && !start;

  loader_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .accept     (accept),
    .byte_data  (byte_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= 32'd0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      n_words  <= '0;
      wcnt     <= '0;
      last_p   <= 1'b0;
      to_cnt   <= '0;
    end else begin
      we <= 1'b0;
      if (start) begin
        state    <= ST_HDR;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
        waddr    <= '0;
        wcnt     <= '0;
        last_p   <= 1'b0;
        to_cnt   <= '0;
      end else begin
        case (state)
          ST_HDR: begin
            if (byte_valid) begin
              n_words <= sat_count(byte_data[ADDR_W:0]);
              state   <= ST_DATA;
              to_cnt  <= '0;
            end else if (to_cnt == TO_LAST) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (byte_valid) begin
              to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
            if (word_ready) begin
              we     <= 1'b1;
              wdata  <= word;
              wcnt   <= wcnt + 1'b1;
              last_p <= ((wcnt + 1'b1) == n_words);
            end
            // Address advances the cycle after each pulse; the final pulse
            // also releases the CPU and leaves waddr at N mod depth.
            if (we) begin
              waddr <= waddr + 1'b1;
              if (last_p) begin
                state    <= ST_IDLE;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
                last_p   <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a short timeout; writes are captured
// on the falling edge and compared against hand-computed words.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  logic [37:0] wq[$];
  int          dbl_we = 0;
  logic        prev_we = 1'b0;
  int          base;

  inst_loader #(.ADDR_W(6), .TIMEOUT(16), .TO_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) wq.push_back({waddr, wdata});
    if (we && prev_we) dbl_we++;
    prev_we = we;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [5:0] a, input logic [31:0] d);
    if (idx < wq.size()) chk(tag, 64'(wq[idx]), 64'({a, d}));
    else chk({tag, "_missing"}, 64'(wq.size()), 64'(idx + 1));
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Two-word load
    base = wq.size();
    do_start();
    chk("t1_hold", 64'(cpu_hold), 64'd1);
    chk("t1_done_clr", 64'(done), 64'd0);
    send(8'h02);
    send_word(32'h28033046);
    chk("t1_we_lat", 64'(we), 64'd1);
    send_word(32'h00101464);
    idle(1);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_hold_off", 64'(cpu_hold), 64'd0);
    chk("t1_waddr", 64'(waddr), 64'd2);
    idle(2);
    chk("t1_nwr", 64'(wq.size() - base), 64'd2);
    chk_write("t1_w0", base, 6'd0, 32'h28033046);
    chk_write("t1_w1", base + 1, 6'd1, 32'h00101464);

    // Bytes in IDLE are ignored
    send(8'hAB); send(8'hCD); send(8'hEF); send(8'h01); send(8'h02);
    idle(2);
    chk("idle_nwr", 64'(wq.size() - base), 64'd2);
    chk("idle_waddr", 64'(waddr), 64'd2);
    chk("idle_done", 64'(done), 64'd1);
    chk("idle_wdata", 64'(wdata), 64'h00101464);

    // Header 00: full 64-word load, address wraps
    base = wq.size();
    do_start();
    send(8'h00);
    for (int i = 0; i < 64; i++) send_word(32'(i));
    idle(2);
    chk("t2_nwr", 64'(wq.size() - base), 64'd64);
    for (int i = 0; i < 64; i++) chk_write("t2_w", base + i, 6'(i), 32'(i));
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_hold", 64'(cpu_hold), 64'd0);
    chk("t2_waddr", 64'(waddr), 64'd0);

    // Header above 64 saturates: 0x7F -> 64 words, not done after 63
    base = wq.size();
    do_start();
    send(8'h7F);
    for (int i = 0; i < 63; i++) send_word(32'hA5000000 | 32'(i));
    idle(2);
    chk("sat_not_done", 64'(done), 64'd0);
    chk("sat_hold", 64'(cpu_hold), 64'd1);
    send_word(32'hA500003F);
    idle(2);
    chk("sat_done", 64'(done), 64'd1);
    chk("sat_nwr", 64'(wq.size() - base), 64'd64);

    // Back-to-back, N=3
    base = wq.size();
    dbl_we = 0;
    do_start();
    send(8'h03);
    send_word(32'h11223344);
    send_word(32'h55667788);
    send_word(32'h99AABBCC);
    idle(2);
    chk("t3_nwr", 64'(wq.size() - base), 64'd3);
    chk_write("t3_w0", base, 6'd0, 32'h11223344);
    chk_write("t3_w1", base + 1, 6'd1, 32'h55667788);
    chk_write("t3_w2", base + 2, 6'd2, 32'h99AABBCC);
    chk("t3_pulse1", 64'(dbl_we), 64'd0);
    chk("t3_waddr", 64'(waddr), 64'd3);
    chk("t3_done", 64'(done), 64'd1);

    // Timeout after 16 idle cycles
    base = wq.size();
    do_start();
    send(8'h01);
    send(8'h3C);
    send(8'h00);
    idle(15);
    chk("t4_err_early", 64'(err), 64'd0);
    idle(1);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_hold", 64'(cpu_hold), 64'd1);
    chk("t4_done", 64'(done), 64'd0);
    send(8'h11); send(8'h22);
    idle(3);
    chk("t4_err_sticky", 64'(err), 64'd1);
    chk("t4_nwr", 64'(wq.size() - base), 64'd0);
    do_start();
    chk("t4_err_clr", 64'(err), 64'd0);
    chk("t4_hold2", 64'(cpu_hold), 64'd1);

    // Restart with a same-cycle byte that must be dropped
    base = wq.size();
    do_start();
    send(8'h02);
    send(8'h28);
    send(8'h03);
    start = 1'b1;
    send(8'hAA);
    start = 1'b0;
    send(8'h01);
    send_word(32'h48000001);
    idle(2);
    chk("t5_nwr", 64'(wq.size() - base), 64'd1);
    chk_write("t5_w0", base, 6'd0, 32'h48000001);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_waddr", 64'(waddr), 64'd1);

    // Async reset while a write pulse is up
    base = wq.size();
    do_start();
    send(8'h01);
    send_word(32'h12345678);
    chk("t6_we_up", 64'(we), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_we", 64'(we), 64'd0);
    chk("t6_hold", 64'(cpu_hold), 64'd0);
    chk("t6_wdata", 64'(wdata), 64'd0);
    chk("t6_waddr", 64'(waddr), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_err", 64'(err), 64'd0);
    idle(2);
    rst = 1'b0;
    idle(3);
    chk("t6_nwr", 64'(wq.size() - base), 64'd0);

    // Reset in the middle of a word, then a clean load from scratch
    base = wq.size();
    do_start();
    send(8'h01);
    send(8'hDE);
    send(8'hAD);
    #2 rst = 1'b1;
    #1;
    chk("t7_hold", 64'(cpu_hold), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    send(8'hBE);
    send(8'hEF);
    idle(3);
    chk("t7_nwr", 64'(wq.size() - base), 64'd0);
    do_start();
    send(8'h01);
    send_word(32'hCAFEF00D);
    idle(2);
    chk_write("t7_w0", base, 6'd0, 32'hCAFEF00D);
    chk("t7_done", 64'(done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
